// File: rtl/mgt_01_i_wb_arbiter.sv
// Write-back arbiter for the MicroGT-01 integer register file: round-robin grant of the
// single write port, registered write stage, and a 32-entry busy scoreboard for hazards.
module mgt_01_i_wb_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  clk_en_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   input  logic [N_REQ*5-1:0]    req_addr_i,
   input  logic [N_REQ*32-1:0]   req_data_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  logic                  sb_set_i,
   input  logic [4:0]            sb_set_addr_i,
   input  logic [4:0]            chk_rs1_i,
   input  logic [4:0]            chk_rs2_i,
   input  logic [4:0]            chk_rd_i,
   output logic                  hazard_o,
   output logic [31:0]           busy_o,
   output logic                  rf_we_o,
   output logic [4:0]            rf_waddr_o,
   output logic [31:0]           rf_wdata_o
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             rf_we_q, rf_we_d;
   logic [4:0]       rf_waddr_q, rf_waddr_d;
   logic [31:0]      rf_wdata_q, rf_wdata_d;
   logic [31:0]      busy_q, busy_d;

   logic [N_REQ-1:0] grant;
   logic [PTR_W-1:0] grant_idx;
   logic             handshake;
   logic [4:0]       sel_addr;
   logic [31:0]      sel_data;
   int               scan_idx;
   int               ptr_next;

   // Scan from the pointer; a stall or reset suppresses every grant so no handshake completes.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      handshake = 1'b0;
      scan_idx  = 0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = (int'(rr_ptr_q) + i) % N_REQ;
         if (!handshake && req_valid_i[scan_idx]) begin
            handshake           = 1'b1;
            grant[scan_idx]     = 1'b1;
            grant_idx           = scan_idx[PTR_W-1:0];
         end
      end
      if (!clk_en_i || !rst_n_i) begin
         grant     = '0;
         handshake = 1'b0;
      end
   end

   always_comb begin
      sel_addr = req_addr_i[int'(grant_idx)*5 +: 5];
      sel_data = req_data_i[int'(grant_idx)*32 +: 32];
      ptr_next = (int'(grant_idx) + 1) % N_REQ;
      rr_ptr_d = handshake ? ptr_next[PTR_W-1:0] : rr_ptr_q;
   end

   always_comb begin
      rf_we_d    = rf_we_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (clk_en_i) begin
         if (handshake) begin
            rf_we_d    = (sel_addr != 5'd0);
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
         end else begin
            rf_we_d = 1'b0;
         end
      end
   end

   // Clear on commit first so a same-cycle dispatch to the same register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (clk_en_i) begin
         if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
         end
         if (sb_set_i && (sb_set_addr_i != 5'd0)) begin
            busy_d[sb_set_addr_i] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rr_ptr_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= 5'd0;
         rf_wdata_q <= 32'd0;
         busy_q     <= 32'd0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   assign req_ready_o = grant;
   assign hazard_o    = busy_q[chk_rs1_i] | busy_q[chk_rs2_i] | busy_q[chk_rd_i];
   assign busy_o      = busy_q;
   assign rf_we_o     = rf_we_q;
   assign rf_waddr_o  = rf_waddr_q;
   assign rf_wdata_o  = rf_wdata_q;

endmodule

// File: tb/tb_mgt_01_i_wb_arbiter.sv
// Self-checking bench for mgt_01_i_wb_arbiter: expected register-file writes go through a
// scoreboard queue; grants, busy bits and hazards are checked against bench constants.
module tb_mgt_01_i_wb_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clk_en;
   logic [3:0]    req_valid;
   logic [19:0]   req_addr;
   logic [127:0]  req_data;
   logic [3:0]    req_ready;
   logic          sb_set;
   logic [4:0]    sb_set_addr;
   logic [4:0]    chk_rs1, chk_rs2, chk_rd;
   logic          hazard;
   logic [31:0]   busy;
   logic          rf_we;
   logic [4:0]    rf_waddr;
   logic [31:0]   rf_wdata;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] rf_model [32];

   always #5 clk = ~clk;

   mgt_01_i_wb_arbiter #(.N_REQ(4)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .clk_en_i      (clk_en),
      .req_valid_i   (req_valid),
      .req_addr_i    (req_addr),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .sb_set_i      (sb_set),
      .sb_set_addr_i (sb_set_addr),
      .chk_rs1_i     (chk_rs1),
      .chk_rs2_i     (chk_rs2),
      .chk_rd_i      (chk_rd),
      .hazard_o      (hazard),
      .busy_o        (busy),
      .rf_we_o       (rf_we),
      .rf_waddr_o    (rf_waddr),
      .rf_wdata_o    (rf_wdata)
   );

   // Register file model: commits on the same gated edge as the real one.
   always @(posedge clk) begin
      if (clk_en && rf_we) rf_model[rf_waddr] <= rf_wdata;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
      req_valid[k]        = v;
      req_addr[k*5 +: 5]  = a;
      req_data[k*32 +: 32] = d;
   endtask

   task automatic push_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
      wr_t w;
      w.we = we; w.addr = a; w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; clk_en = 1'b1; sb_set = 1'b0; sb_set_addr = '0;
      chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
      for (int k = 0; k < 4; k++) set_req(k, 1'b1, 5'(10 + k), 32'hA000_0000 + 32'(k));
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (req_ready !== 4'b0000 || rf_we !== 1'b0 || busy !== 32'd0 || hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b we=%b busy=%h hazard=%b, expected 0000/0/0/0",
                     req_ready, rf_we, busy, hazard);
         end
      end
      rst_n = 1'b1;
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL reset_first_grant: ready=%b expected 0001", req_ready);
      end
   endtask

   task automatic test_round_robin;
      wr_t e;
      logic [4:0]  last_addr;
      logic [31:0] last_data;
      last_addr = '0; last_data = '0;
      for (int i = 0; i < 8; i++) begin
         int g;
         g = i % 4;
         checks++;
         if (req_ready !== 4'(1 << g)) begin
            errors++;
            $display("[TB] FAIL rr_grant_%0d: ready=%b expected %b", i, req_ready, 4'(1 << g));
         end
         last_addr = req_addr[g*5 +: 5];
         last_data = req_data[g*32 +: 32];
         push_wr(1'b1, last_addr, last_data);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL rr_write_%0d: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                     i, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
         end
         set_req(g, 1'b1, 5'(10 + g), 32'hB000_0000 + 32'(i));
         settle();
      end
      req_valid = 4'b0000;
      settle();
      checks++;
      if (req_ready !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL rr_idle_ready: ready=%b expected 0000", req_ready);
      end
      push_wr(1'b0, last_addr, last_data);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
         errors++;
         $display("[TB] FAIL rr_idle_hold: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                  rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
      end
   endtask

   task automatic test_scoreboard;
      wr_t e;
      sb_set = 1'b1; sb_set_addr = 5'd5; chk_rs1 = 5'd5;
      settle();
      checks++;
      if (hazard !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sb_no_bypass: hazard=%b expected 0", hazard);
      end
      tick();
      sb_set = 1'b0;
      settle();
      checks++;
      if (busy !== 32'h0000_0020 || hazard !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sb_set_x5: busy=%h hazard=%b, expected 00000020/1", busy, hazard);
      end
      set_req(3, 1'b1, 5'd5, 32'hDEAD_BEEF);
      settle();
      checks++;
      if (req_ready !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL sb_div_grant: ready=%b expected 1000", req_ready);
      end
      push_wr(1'b1, 5'd5, 32'hDEAD_BEEF);
      tick();
      set_req(3, 1'b0, 5'd5, 32'hDEAD_BEEF);
      settle();
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || busy !== 32'h20 || hazard !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sb_div_write: got we=%b addr=%0d data=%h busy=%h hz=%b, expected we=%b addr=%0d data=%h busy=00000020 hz=1",
                  rf_we, rf_waddr, rf_wdata, busy, hazard, e.we, e.addr, e.data);
      end
      tick();
      checks++;
      if (busy !== 32'd0 || hazard !== 1'b0 || rf_we !== 1'b0 || rf_model[5] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL sb_commit_x5: busy=%h hazard=%b we=%b rf[5]=%h, expected 0/0/0/deadbeef",
                  busy, hazard, rf_we, rf_model[5]);
      end
      chk_rs1 = '0;
   endtask

   task automatic test_x0;
      wr_t e;
      sb_set = 1'b1; sb_set_addr = 5'd0;
      tick();
      sb_set = 1'b0;
      checks++;
      if (busy !== 32'd0) begin
         errors++;
         $display("[TB] FAIL x0_busy: busy=%h expected 00000000", busy);
      end
      set_req(1, 1'b1, 5'd0, 32'h1234_5678);
      settle();
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL x0_lsu_grant: ready=%b expected 0010", req_ready);
      end
      push_wr(1'b0, 5'd0, 32'h1234_5678);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
         errors++;
         $display("[TB] FAIL x0_write: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                  rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
      end
      set_req(1, 1'b1, 5'd15, 32'h0F0F_0F0F);
      set_req(2, 1'b1, 5'd14, 32'h0E0E_0E0E);
      settle();
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL x0_ptr_advance: ready=%b expected 0100", req_ready);
      end
      push_wr(1'b1, 5'd14, 32'h0E0E_0E0E);
      tick();
      set_req(2, 1'b0, 5'd14, 32'h0E0E_0E0E);
      settle();
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL x0_mul_write: got we=%b addr=%0d data=%h ready=%b, expected we=%b addr=%0d data=%h ready=0010",
                  rf_we, rf_waddr, rf_wdata, req_ready, e.we, e.addr, e.data);
      end
      push_wr(1'b1, 5'd15, 32'h0F0F_0F0F);
      tick();
      set_req(1, 1'b0, 5'd15, 32'h0F0F_0F0F);
      settle();
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
         errors++;
         $display("[TB] FAIL x0_lsu_retry: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                  rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
      end
   endtask

   task automatic test_same_cycle;
      wr_t e;
      sb_set = 1'b1; sb_set_addr = 5'd7; chk_rd = 5'd7;
      tick();
      sb_set = 1'b0;
      settle();
      checks++;
      if (busy !== 32'h0000_0080 || hazard !== 1'b1) begin
         errors++;
         $display("[TB] FAIL same_set_x7: busy=%h hazard=%b, expected 00000080/1", busy, hazard);
      end
      set_req(0, 1'b1, 5'd7, 32'h0000_0077);
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL same_alu_grant: ready=%b expected 0001", req_ready);
      end
      push_wr(1'b1, 5'd7, 32'h0000_0077);
      tick();
      set_req(0, 1'b0, 5'd7, 32'h0000_0077);
      sb_set = 1'b1; sb_set_addr = 5'd7;
      settle();
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
         errors++;
         $display("[TB] FAIL same_write: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                  rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
      end
      tick();
      sb_set = 1'b0;
      checks++;
      if (busy !== 32'h0000_0080 || rf_model[7] !== 32'h0000_0077) begin
         errors++;
         $display("[TB] FAIL same_set_wins: busy=%h rf[7]=%h, expected 00000080/00000077", busy, rf_model[7]);
      end
      set_req(0, 1'b1, 5'd7, 32'h0000_0078);
      settle();
      push_wr(1'b1, 5'd7, 32'h0000_0078);
      tick();
      set_req(0, 1'b0, 5'd7, 32'h0000_0078);
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || busy !== 32'h80) begin
         errors++;
         $display("[TB] FAIL same_rewrite: got we=%b addr=%0d data=%h busy=%h, expected we=%b addr=%0d data=%h busy=00000080",
                  rf_we, rf_waddr, rf_wdata, busy, e.we, e.addr, e.data);
      end
      tick();
      checks++;
      if (busy !== 32'd0 || hazard !== 1'b0) begin
         errors++;
         $display("[TB] FAIL same_final_clear: busy=%h hazard=%b, expected 0/0", busy, hazard);
      end
      chk_rd = '0;
   endtask

   task automatic test_stall;
      wr_t e;
      sb_set = 1'b1; sb_set_addr = 5'd9;
      tick();
      sb_set = 1'b0;
      set_req(2, 1'b1, 5'd9, 32'h0000_0099);
      settle();
      checks++;
      if (req_ready !== 4'b0100 || busy !== 32'h0000_0200) begin
         errors++;
         $display("[TB] FAIL stall_setup: ready=%b busy=%h, expected 0100/00000200", req_ready, busy);
      end
      push_wr(1'b1, 5'd9, 32'h0000_0099);
      tick();
      set_req(2, 1'b0, 5'd9, 32'h0000_0099);
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data) begin
         errors++;
         $display("[TB] FAIL stall_write: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                  rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
      end
      clk_en = 1'b0;
      set_req(0, 1'b1, 5'd16, 32'h0000_1616);
      sb_set = 1'b1; sb_set_addr = 5'd20;
      for (int c = 0; c < 3; c++) begin
         settle();
         checks++;
         if (req_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stall_ready_%0d: ready=%b expected 0000", c, req_ready);
         end
         tick();
         checks++;
         if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 || busy !== 32'h200) begin
            errors++;
            $display("[TB] FAIL stall_hold_%0d: we=%b addr=%0d data=%h busy=%h, expected 1/9/00000099/00000200",
                     c, rf_we, rf_waddr, rf_wdata, busy);
         end
      end
      clk_en = 1'b1;
      sb_set = 1'b0;
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL stall_resume_grant: ready=%b expected 0001", req_ready);
      end
      push_wr(1'b1, 5'd16, 32'h0000_1616);
      tick();
      set_req(0, 1'b0, 5'd16, 32'h0000_1616);
      e = exp_q.pop_front();
      checks++;
      if (rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data || busy !== 32'd0 || rf_model[9] !== 32'h99) begin
         errors++;
         $display("[TB] FAIL stall_release: got we=%b addr=%0d data=%h busy=%h rf[9]=%h, expected we=%b addr=%0d data=%h busy=0 rf[9]=00000099",
                  rf_we, rf_waddr, rf_wdata, busy, rf_model[9], e.we, e.addr, e.data);
      end
   endtask

   task automatic test_reset_mid;
      sb_set = 1'b1; sb_set_addr = 5'd20;
      set_req(1, 1'b1, 5'd21, 32'h0000_2121);
      settle();
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL mid_grant: ready=%b expected 0010", req_ready);
      end
      tick();
      sb_set = 1'b0;
      rst_n = 1'b0;
      req_valid = 4'b1111;
      settle();
      checks++;
      if (req_ready !== 4'b0000 || rf_we !== 1'b1 || busy !== 32'h0010_0000) begin
         errors++;
         $display("[TB] FAIL mid_pre_reset: ready=%b we=%b busy=%h, expected 0000/1/00100000", req_ready, rf_we, busy);
      end
      tick();
      checks++;
      if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || busy !== 32'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset_clear: we=%b addr=%0d data=%h busy=%h, expected 0/0/0/0",
                  rf_we, rf_waddr, rf_wdata, busy);
      end
      rst_n = 1'b1;
      settle();
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL mid_ptr_reset: ready=%b expected 0001", req_ready);
      end
      req_valid = 4'b0000;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;
      req_valid = '0; req_addr = '0; req_data = '0;
      test_reset();
      test_round_robin();
      test_scoreboard();
      test_x0();
      test_same_cycle();
      test_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
